// File: rtl/noc_ni_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | noc_ni_pkg: shared flit encodings and FSM state types for the NoC NI.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package noc_ni_pkg;

  localparam int NI_DATA_W = 32;
  localparam int FLIT_W    = NI_DATA_W + 2;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_TAIL = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HEAD = 2'd0,
    RX_BODY = 2'd1,
    RX_DROP = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ni_sync_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ni_sync_fifo: show-ahead synchronous FIFO with wrap pointers + count.  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module ni_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);
  localparam logic [PW:0]   c_depth = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != c_depth);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_network_interface.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | noc_network_interface: packetizes core words into HEAD/TAIL flits and  |
// | reassembles inbound packets for the core.            Rev 1.0           |
// +-------------------------------------------------------------------------+
module noc_network_interface
  import noc_ni_pkg::*;
#(
  parameter int                ADDR_W   = 2,
  parameter logic [ADDR_W-1:0] NODE_ID  = '0,
  parameter int                DATA_W   = NI_DATA_W,
  parameter int                TX_DEPTH = 4,
  parameter int                RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_valid,
  input  logic [ADDR_W-1:0] proc_dest,
  input  logic [DATA_W-1:0] proc_data,
  output logic              ni_ready,
  input  logic              proc_ready_in,
  output logic              mips_ni,
  output logic              data_valid,
  output logic [DATA_W-1:0] wd_NI,
  output logic [DATA_W+1:0] flit_out,
  output logic              flit_out_valid,
  input  logic              flit_out_ready,
  input  logic [DATA_W+1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic              tx_overflow,
  output logic              rx_err
);

  localparam int c_tx_w  = ADDR_W + DATA_W;
  localparam int c_tx_cw = $clog2(TX_DEPTH) + 1;
  localparam int c_rx_cw = $clog2(RX_DEPTH) + 1;
  localparam logic [c_tx_cw-1:0] c_tx_one = c_tx_cw'(1);

  // ---------------------------------------------------------------- TX path
  logic               w_tx_push;
  logic               w_tx_pop;
  logic               w_tx_full;
  logic               w_tx_empty;
  logic [c_tx_cw-1:0] w_tx_count;
  logic [c_tx_w-1:0]  w_tx_head;
  logic               w_tx_more;
  logic [DATA_W-1:0]  w_head_pl;
  tx_state_t          r_tx_state;
  tx_state_t          w_tx_next;
  logic               r_tx_ovf;

  assign ni_ready       = !w_tx_full;
  assign w_tx_push      = proc_valid && !w_tx_full;
  assign w_tx_pop       = (r_tx_state == TX_TAIL) && flit_out_ready;
  assign w_tx_more      = (w_tx_count > c_tx_one) || w_tx_push;
  assign flit_out_valid = (r_tx_state == TX_HEAD) || (r_tx_state == TX_TAIL);
  assign tx_overflow    = r_tx_ovf;

  ni_sync_fifo #(
    .WIDTH (c_tx_w),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  ({proc_dest, proc_data}),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) w_tx_next = TX_HEAD;
      TX_HEAD: if (flit_out_ready) w_tx_next = TX_TAIL;
      TX_TAIL: if (flit_out_ready) w_tx_next = w_tx_more ? TX_HEAD : TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Flit content comes straight from the FIFO head, so it is stable until the pop.
  always_comb begin
    w_head_pl = '0;
    w_head_pl[DATA_W-1 -: ADDR_W]        = w_tx_head[c_tx_w-1 -: ADDR_W];
    w_head_pl[DATA_W-1-ADDR_W -: ADDR_W] = NODE_ID;
    case (r_tx_state)
      TX_HEAD: flit_out = {FLIT_HEAD, w_head_pl};
      TX_TAIL: flit_out = {FLIT_TAIL, w_tx_head[DATA_W-1:0]};
      default: flit_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_ovf   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (proc_valid && w_tx_full) begin
        r_tx_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [1:0]         w_rx_type;
  logic [ADDR_W-1:0]  w_rx_dest;
  logic               w_rx_fire;
  logic               w_rx_push;
  logic               w_rx_err_set;
  logic               w_rx_full;
  logic               w_rx_empty;
  logic [c_rx_cw-1:0] w_rx_count;
  logic [DATA_W-1:0]  w_rx_head;
  rx_state_t          r_rx_state;
  rx_state_t          w_rx_next;
  logic               r_rx_err;
  logic [DATA_W-1:0]  r_wd_hold;

  assign w_rx_type  = flit_in[DATA_W+1 -: 2];
  assign w_rx_dest  = flit_in[DATA_W-1 -: ADDR_W];
  assign w_rx_fire  = flit_in_valid && flit_in_ready;
  assign mips_ni    = !w_rx_empty;
  assign data_valid = mips_ni && proc_ready_in;
  assign wd_NI      = (w_rx_count == '0) ? r_wd_hold : w_rx_head;
  assign rx_err     = r_rx_err;

  ni_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (flit_in[DATA_W-1:0]),
    .i_pop   (data_valid),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_comb begin
    case (r_rx_state)
      RX_HEAD: flit_in_ready = 1'b1;
      RX_BODY: flit_in_ready = !w_rx_full;
      RX_DROP: flit_in_ready = 1'b1;
      default: flit_in_ready = 1'b0;
    endcase
  end

  // A HEAD seen while waiting for a TAIL restarts the packet but is still an error.
  always_comb begin
    w_rx_next    = r_rx_state;
    w_rx_push    = 1'b0;
    w_rx_err_set = 1'b0;
    if (w_rx_fire) begin
      case (r_rx_state)
        RX_HEAD, RX_BODY: begin
          if (w_rx_type == FLIT_HEAD) begin
            w_rx_err_set = (r_rx_state == RX_BODY) || (w_rx_dest != NODE_ID);
            w_rx_next    = (w_rx_dest == NODE_ID) ? RX_BODY : RX_DROP;
          end else if ((w_rx_type == FLIT_TAIL) && (r_rx_state == RX_BODY)) begin
            w_rx_push = 1'b1;
            w_rx_next = RX_HEAD;
          end else begin
            w_rx_err_set = 1'b1;
          end
        end
        RX_DROP: w_rx_next = RX_HEAD;
        default: w_rx_next = RX_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_HEAD;
      r_rx_err   <= 1'b0;
      r_wd_hold  <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_rx_err_set) begin
        r_rx_err <= 1'b1;
      end
      if (data_valid) begin
        r_wd_hold <= w_rx_head;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_network_interface.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_noc_network_interface: vector table, corner sequences and a        |
// | randomized run against a queue-based reference.        Rev 1.0        |
// +-------------------------------------------------------------------------+
module tb_noc_network_interface;

  logic        clk;
  logic        rst;
  logic        proc_valid;
  logic [1:0]  proc_dest;
  logic [31:0] proc_data;
  logic        ni_ready;
  logic        proc_ready_in;
  logic        mips_ni;
  logic        data_valid;
  logic [31:0] wd_NI;
  logic [33:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [33:0] flit_in;
  logic        flit_in_valid;
  logic        flit_in_ready;
  logic        tx_overflow;
  logic        rx_err;

  int n_vec = 0;
  int n_mis = 0;

  noc_network_interface dut (
    .clk            (clk),
    .rst            (rst),
    .proc_valid     (proc_valid),
    .proc_dest      (proc_dest),
    .proc_data      (proc_data),
    .ni_ready       (ni_ready),
    .proc_ready_in  (proc_ready_in),
    .mips_ni        (mips_ni),
    .data_valid     (data_valid),
    .wd_NI          (wd_NI),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .flit_in_ready  (flit_in_ready),
    .tx_overflow    (tx_overflow),
    .rx_err         (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [1:0]  pdest;
    logic [31:0] pdata;
    logic        fordy;
    logic [33:0] fin;
    logic        finv;
    logic        prdy;
    logic        e_nir;
    logic        e_fov;
    logic [33:0] e_fo;
    logic        e_mips;
    logic        e_dv;
    logic [31:0] e_wd;
    logic        e_finrdy;
    logic        e_err;
  } vec_t;

  function automatic logic [33:0] head_of(input logic [1:0] dest);
    return {2'b01, dest, 2'd0, 28'd0};
  endfunction

  function automatic logic [33:0] tail_of(input logic [31:0] data);
    return {2'b10, data};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    proc_valid = 0; proc_dest = 0; proc_data = 0; proc_ready_in = 0;
    flit_out_ready = 0; flit_in = 0; flit_in_valid = 0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic send_flit(input logic [33:0] f);
    bit ok;
    ok = 0;
    flit_in = f;
    flit_in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      settle();
      if (flit_in_ready) ok = 1;
      tick();
    end
    flit_in_valid = 1'b0;
    chk("fin_accept_timeout", ok, 1);
  endtask

  vec_t        tbl[13];
  logic [33:0] exp_fl[8];
  logic [31:0] exp_rx[5];
  logic [33:0] txq[$];
  logic [31:0] rxq[$];
  logic [33:0] gen[$];

  initial begin
    int k;
    bit tx_tail_next, e_ovf, e_err, acc, exp_frdy, fin_hs;
    int rx_phase;
    logic [33:0] f, ef;
    logic [1:0] d;

    // ---------------- reset state
    do_reset();
    settle();
    chk("rst_ni_ready", ni_ready, 1);
    chk("rst_fov", flit_out_valid, 0);
    chk("rst_mips", mips_ni, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_wd", wd_NI, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_fin_rdy", flit_in_ready, 1);

    // ---------------- table: single send, RX delivery, misroute
    do_reset();
    tbl[0]  = '{1, 2'd2, 32'hDEADBEEF, 1, 34'h0, 0, 0,  1, 0, 34'h0, 0, 0, 32'h0, 1, 0};
    tbl[1]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 0, 34'h0, 0, 0, 32'h0, 1, 0};
    tbl[2]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 1, head_of(2'd2), 0, 0, 32'h0, 1, 0};
    tbl[3]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 1, tail_of(32'hDEADBEEF), 0, 0, 32'h0, 1, 0};
    tbl[4]  = '{0, 2'd0, 32'h0, 1, head_of(2'd0), 1, 0, 1, 0, 34'h0, 0, 0, 32'h0, 1, 0};
    tbl[5]  = '{0, 2'd0, 32'h0, 1, tail_of(32'h12345678), 1, 0, 1, 0, 34'h0, 0, 0, 32'h0, 1, 0};
    tbl[6]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 0, 34'h0, 1, 0, 32'h12345678, 1, 0};
    tbl[7]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 0, 34'h0, 1, 0, 32'h12345678, 1, 0};
    tbl[8]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 1,         1, 0, 34'h0, 1, 1, 32'h12345678, 1, 0};
    tbl[9]  = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 1,         1, 0, 34'h0, 0, 0, 32'h12345678, 1, 0};
    tbl[10] = '{0, 2'd0, 32'h0, 1, head_of(2'd3), 1, 0, 1, 0, 34'h0, 0, 0, 32'h12345678, 1, 0};
    tbl[11] = '{0, 2'd0, 32'h0, 1, tail_of(32'hAAAA5555), 1, 0, 1, 0, 34'h0, 0, 0, 32'h12345678, 1, 1};
    tbl[12] = '{0, 2'd0, 32'h0, 1, 34'h0, 0, 0,         1, 0, 34'h0, 0, 0, 32'h12345678, 1, 1};
    for (int i = 0; i < 13; i++) begin
      proc_valid = tbl[i].pv; proc_dest = tbl[i].pdest; proc_data = tbl[i].pdata;
      flit_out_ready = tbl[i].fordy; flit_in = tbl[i].fin; flit_in_valid = tbl[i].finv;
      proc_ready_in = tbl[i].prdy;
      settle();
      chk($sformatf("v%0d_ni_ready", i), ni_ready, tbl[i].e_nir);
      chk($sformatf("v%0d_fov", i), flit_out_valid, tbl[i].e_fov);
      if (tbl[i].e_fov) chk($sformatf("v%0d_flit", i), flit_out, tbl[i].e_fo);
      chk($sformatf("v%0d_mips", i), mips_ni, tbl[i].e_mips);
      chk($sformatf("v%0d_dv", i), data_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_wd", i), wd_NI, tbl[i].e_wd);
      chk($sformatf("v%0d_fin_rdy", i), flit_in_ready, tbl[i].e_finrdy);
      chk($sformatf("v%0d_err", i), rx_err, tbl[i].e_err);
      tick();
    end
    flit_in_valid = 0; proc_ready_in = 0;

    // ---------------- TX backpressure / overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      proc_valid = 1; proc_dest = 2'(i + 1); proc_data = 32'h1000 + i;
      if (i < 4) begin
        exp_fl[2*i]   = head_of(2'(i + 1));
        exp_fl[2*i+1] = tail_of(32'h1000 + i);
      end
      settle();
      chk($sformatf("ovf_ni_ready%0d", i), ni_ready, (i < 4));
      tick();
    end
    proc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ovf_flag", tx_overflow, 1);
      chk("ovf_hold_valid", flit_out_valid, 1);
      chk("ovf_hold_flit", flit_out, exp_fl[0]);
      tick();
    end
    flit_out_ready = 1;
    k = 0;
    for (int t = 0; t < 40 && k < 8; t++) begin
      settle();
      if (flit_out_valid) begin
        chk($sformatf("ovf_drain%0d", k), flit_out, exp_fl[k]);
        k++;
      end
      tick();
    end
    chk("ovf_drain_count", k, 8);
    settle();
    chk("ovf_idle_after", flit_out_valid, 0);
    tick();

    // ---------------- RX full
    do_reset();
    for (int j = 0; j < 5; j++) exp_rx[j] = 32'hA0 + j;
    for (int j = 0; j < 4; j++) begin
      send_flit(head_of(2'd0));
      send_flit(tail_of(exp_rx[j]));
    end
    send_flit(head_of(2'd0));
    flit_in = tail_of(exp_rx[4]);
    flit_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("full_stall_rdy", flit_in_ready, 0);
      chk("full_mips", mips_ni, 1);
      chk("full_head_wd", wd_NI, exp_rx[0]);
      tick();
    end
    proc_ready_in = 1;
    settle();
    chk("full_pop_dv", data_valid, 1);
    chk("full_pop_wd", wd_NI, exp_rx[0]);
    chk("full_pop_rdy", flit_in_ready, 0);
    tick();
    proc_ready_in = 0;
    settle();
    chk("full_resume_rdy", flit_in_ready, 1);
    tick();
    flit_in_valid = 0;
    proc_ready_in = 1;
    k = 1;
    for (int t = 0; t < 30 && k < 5; t++) begin
      settle();
      if (data_valid) begin
        chk($sformatf("full_deliver%0d", k), wd_NI, exp_rx[k]);
        k++;
      end
      tick();
    end
    chk("full_deliver_count", k, 5);
    settle();
    chk("full_empty_after", mips_ni, 0);
    tick();
    proc_ready_in = 0;

    // ---------------- TAIL arriving in RX_HEAD
    do_reset();
    send_flit(tail_of(32'hBAD0BAD0));
    settle();
    chk("stray_tail_err", rx_err, 1);
    chk("stray_tail_nopush", mips_ni, 0);
    tick();

    // ---------------- reset mid-packet
    do_reset();
    send_flit(tail_of(32'h1));
    for (int i = 0; i < 5; i++) begin
      proc_valid = 1; proc_dest = 2'd1; proc_data = 32'h2000 + i;
      tick();
    end
    proc_valid = 0;
    flit_out_ready = 1;
    tick();
    flit_out_ready = 0;
    settle();
    chk("mid_in_tail", flit_out, tail_of(32'h2000));
    tick();
    send_flit(head_of(2'd0));
    send_flit(tail_of(32'h66));
    send_flit(head_of(2'd0));
    settle();
    chk("mid_pre_mips", mips_ni, 1);
    chk("mid_pre_flags", {tx_overflow, rx_err}, 2'b11);
    tick();
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("mid_rst_fov", flit_out_valid, 0);
    chk("mid_rst_mips", mips_ni, 0);
    chk("mid_rst_ovf", tx_overflow, 0);
    chk("mid_rst_err", rx_err, 0);
    chk("mid_rst_ni_ready", ni_ready, 1);
    tick();
    flit_out_ready = 1;
    proc_valid = 1; proc_dest = 2'd3; proc_data = 32'h55;
    tick();
    proc_valid = 0;
    settle();
    chk("mid_fresh_gap", flit_out_valid, 0);
    tick();
    settle();
    chk("mid_fresh_head", flit_out, head_of(2'd3));
    tick();
    settle();
    chk("mid_fresh_tail", flit_out, tail_of(32'h55));
    tick();
    send_flit(head_of(2'd0));
    send_flit(tail_of(32'h77));
    settle();
    chk("mid_fresh_mips", mips_ni, 1);
    chk("mid_fresh_wd", wd_NI, 32'h77);
    chk("mid_fresh_err", rx_err, 0);
    tick();

    // ---------------- randomized run against queue reference
    do_reset();
    txq.delete(); rxq.delete(); gen.delete();
    tx_tail_next = 0; e_ovf = 0; e_err = 0; rx_phase = 0;
    for (int c = 0; c < 800; c++) begin
      proc_valid     = ($urandom % 2) == 0;
      proc_dest      = 2'($urandom);
      proc_data      = $urandom;
      flit_out_ready = ($urandom % 4) != 0;
      proc_ready_in  = ($urandom % 3) == 0;
      if (gen.size() == 0) begin
        d = (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        gen.push_back({2'b01, d, 2'd1, 28'($urandom)});
        gen.push_back(tail_of($urandom));
      end
      flit_in       = gen[0];
      flit_in_valid = ($urandom % 4) != 0;
      settle();

      chk("rnd_ni_ready", ni_ready, txq.size() < 4);
      chk("rnd_ovf", tx_overflow, e_ovf);
      chk("rnd_err", rx_err, e_err);
      chk("rnd_mips", mips_ni, rxq.size() != 0);
      chk("rnd_dv", data_valid, (rxq.size() != 0) && proc_ready_in);
      exp_frdy = (rx_phase == 1) ? (rxq.size() < 4) : 1'b1;
      chk("rnd_fin_rdy", flit_in_ready, exp_frdy);
      if (data_valid && rxq.size() != 0) chk("rnd_wd", wd_NI, rxq[0]);
      if (flit_out_valid && flit_out_ready) begin
        if (txq.size() == 0) begin
          chk("rnd_spurious_flit", flit_out_valid, 0);
        end else begin
          ef = tx_tail_next ? tail_of(txq[0][31:0]) : head_of(txq[0][33:32]);
          chk("rnd_flit", flit_out, ef);
        end
      end

      acc = proc_valid && (txq.size() < 4);
      if (proc_valid && !acc) e_ovf = 1;
      if (flit_out_valid && flit_out_ready && txq.size() != 0) begin
        if (tx_tail_next) void'(txq.pop_front());
        tx_tail_next = !tx_tail_next;
      end
      if (acc) txq.push_back({proc_dest, proc_data});
      if (proc_ready_in && rxq.size() != 0) void'(rxq.pop_front());
      fin_hs = flit_in_valid && flit_in_ready;
      if (fin_hs) begin
        f = gen.pop_front();
        case (rx_phase)
          0: begin
            if (f[31:30] == 2'd0) rx_phase = 1;
            else begin
              rx_phase = 2;
              e_err = 1;
            end
          end
          1: begin
            rxq.push_back(f[31:0]);
            rx_phase = 0;
          end
          default: rx_phase = 0;
        endcase
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_network_interface.md
Name: noc_network_interface

Overview:
- Network-side endpoint for the pipelined MIPS core's NoC port.
- TX path: takes the core's outbound word (proc_valid / 2-bit destination / 32-bit data) and packetizes it into a two-flit packet (HEAD, TAIL) for the local router port.
- RX path: reassembles inbound two-flit packets from the router and hands the 32-bit payload to the core on wd_NI, qualified by mips_ni / data_valid.

Parameters:
- NODE_ID, 2'd0, this node's address; carried in HEAD src field, compared against HEAD dest on RX.
- ADDR_W, 2, node address width.
- DATA_W, 32, payload width.
- TX_DEPTH, 4, outbound word FIFO entries (power of 2).
- RX_DEPTH, 4, inbound word FIFO entries (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- proc_valid  in  1  core offers an outbound word this cycle
- proc_dest  in  ADDR_W  destination node of the offered word
- proc_data  in  DATA_W  offered word
- ni_ready  out  1  TX FIFO not full; word accepted when proc_valid && ni_ready
- proc_ready_in  in  1  core can take an inbound word this cycle
- mips_ni  out  1  RX FIFO non-empty (inbound word pending)
- data_valid  out  1  inbound word transferred to core this cycle
- wd_NI  out  DATA_W  inbound word (RX FIFO head, show-ahead)
- flit_out  out  DATA_W+2  flit to router, [DATA_W+1:DATA_W] = type
- flit_out_valid  out  1  flit_out valid
- flit_out_ready  in  1  router accepts flit_out
- flit_in  in  DATA_W+2  flit from router
- flit_in_valid  in  1  flit_in valid
- flit_in_ready  out  1  NI accepts flit_in
- tx_overflow  out  1  sticky: proc_valid seen while ni_ready low
- rx_err  out  1  sticky: protocol error or misrouted packet

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - Both FIFOs empty; TX FSM = TX_IDLE; RX FSM = RX_HEAD.
  - flit_out_valid = 0, mips_ni = 0, data_valid = 0.
  - tx_overflow = 0, rx_err = 0.
  - ni_ready = 1 in the first cycle after reset; wd_NI = 0.
- A reset during a packet in flight aborts it. Partial packets are not resumed.
- Flit types: 2'b01 HEAD, 2'b10 TAIL; 2'b00 and 2'b11 are illegal.
- HEAD payload: {dest, src = NODE_ID, zeros}, with dest in bits [DATA_W-1 -: ADDR_W] and src immediately below it.
- TAIL payload: the data word.
- TX path:
  - ni_ready = !tx_full, taken from registered count. No bypass: a full FIFO that is being popped still reports not-ready.
  - Push {proc_dest, proc_data} on an accepted word. proc_valid while full drops the word and sets tx_overflow.
- TX FSM:
  - TX_IDLE: when the FIFO is non-empty, go to TX_HEAD.
  - TX_HEAD: flit_out_valid = 1, HEAD flit driven. On flit_out_ready, go to TX_TAIL.
  - TX_TAIL: TAIL flit driven. On flit_out_ready, pop the FIFO, then go to TX_HEAD if more entries remain after the pop, else TX_IDLE.
- TX latency: a word accepted at edge E0 presents its HEAD in the cycle after E1. Back-to-back packets cost 2 cycles/packet with no idle gap.
- TX ordering: flit_out must stay stable while valid && !ready. HEAD and TAIL of one packet are never interleaved with another packet.
- RX flow control: flit_in_ready = (RX_HEAD) || (RX_BODY && !rx_full).
- RX FSM:
  - RX_HEAD:
    - Legal HEAD with dest == NODE_ID: go to RX_BODY.
    - HEAD with dest != NODE_ID: set rx_err, go to RX_DROP.
    - Any other type: discard it, set rx_err, stay in RX_HEAD.
  - RX_BODY:
    - TAIL: push the payload to the RX FIFO, go to RX_HEAD.
    - HEAD: set rx_err, take it as the new header (re-check dest).
    - Illegal type: set rx_err, discard, stay.
  - RX_DROP: flit_in_ready = 1. Consume one flit, discard it, go to RX_HEAD.
- Core delivery:
  - mips_ni = !rx_empty; wd_NI = RX FIFO head.
  - data_valid = mips_ni && proc_ready_in, combinational. Pop on that edge.
  - A push and a pop in the same cycle are both honoured.
  - wd_NI holds its last value when the FIFO is empty.
- FIFO rules: occupancy counters are ADDR-free modulo pointers with a separate count. Pointers wrap at DEPTH-1 → 0.

Decomposition:
- Package noc_ni_pkg:
  - flit type constants: FLIT_HEAD, FLIT_TAIL.
  - tx_state_t {TX_IDLE, TX_HEAD, TX_TAIL}.
  - rx_state_t {RX_HEAD, RX_BODY, RX_DROP}.
  - FLIT_W = DATA_W+2.
- Sub-module ni_sync_fifo (WIDTH, DEPTH; show-ahead; full/empty/count), instantiated for TX (width ADDR_W+DATA_W) and RX (width DATA_W).
- FSMs and flit formatting live in the top module.

Test Plan:
- Single send: proc_valid=1, dest=2, data=32'hDEADBEEF for 1 cycle, flit_out_ready=1. Expect HEAD flit {01, dest=2, src=0, 0…} two cycles later, then TAIL {10, DEADBEEF} on the next cycle. ni_ready stays 1.
- TX backpressure/overflow: 5 consecutive words with flit_out_ready=0. Expect ni_ready low after 4. The 5th word is dropped and tx_overflow=1. flit_out holds the HEAD of word 0 stable. After releasing ready, 8 flits exit in order.
- RX delivery: inject HEAD(dest=0), TAIL(32'h12345678) with proc_ready_in=0. Expect mips_ni=1, wd_NI=12345678, data_valid=0. Raise proc_ready_in: data_valid pulses 1 cycle, then mips_ni=0.
- RX full: RX FIFO filled with 4 packets, proc_ready_in=0, 5th packet offered. Expect HEAD accepted and flit_in_ready=0 in RX_BODY until one pop. Then the TAIL is accepted and all 5 words are delivered in order.
- Misroute/protocol: HEAD(dest=3) + TAIL → both consumed, no push, rx_err=1. TAIL arriving in RX_HEAD → discarded, rx_err=1.
- Reset mid-packet: rst asserted in TX_TAIL and RX_BODY. Expect flit_out_valid=0, mips_ni=0, flags cleared next cycle, and a fresh packet then works normally.
